// File: rtl/pwd_lock.sv
// pwd_lock: serial password detector, sliding-overlap (MODE 0) or framed attempts with lockout (MODE 1)
module pwd_lock #(
  parameter int PWD_W = 4,
  parameter logic [PWD_W-1:0] PWD_INIT = 4'b1001,
  parameter int MODE = 0,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int FW = $clog2(MAX_FAIL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in,
  input  logic          in_valid,
  input  logic          pwd_we,
  input  logic [PWD_W-1:0] pwd_din,
  output logic          out,
  output logic          locked,
  output logic [FW-1:0] fail_cnt
);
  localparam int CW = $clog2(PWD_W + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  typedef enum logic {COLLECT, LOCKED} state_t;
  state_t           r_state;
  logic [PWD_W-1:0] r_pwd;
  // only the low PWD_W-1 bits of history are ever needed to form the candidate
  logic [PWD_W-2:0] r_sr;
  logic [CW-1:0]    r_fill;
  logic [CW-1:0]    r_bcnt;
  logic [FW-1:0]    r_fail;
  logic [TW-1:0]    r_tmr;
  logic             r_out;
  logic [PWD_W-1:0] w_cand;
  logic             w_match;
  logic             w_full;
  logic             w_last;
  logic [FW:0]      w_fail_inc;
  assign w_cand     = {r_sr, in};
  assign w_match    = w_cand == r_pwd;
  assign w_full     = r_fill >= CW'(PWD_W - 1);
  assign w_last     = r_bcnt == CW'(PWD_W - 1);
  assign w_fail_inc = {1'b0, r_fail} + {{FW{1'b0}}, 1'b1};
  assign out        = r_out;
  assign locked     = r_state == LOCKED;
  assign fail_cnt   = r_fail;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
      r_pwd   <= PWD_INIT;
      r_sr    <= '0;
      r_fill  <= '0;
      r_bcnt  <= '0;
      r_fail  <= '0;
      r_tmr   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_out <= 1'b0;
      if (r_state == LOCKED) begin
        r_tmr <= r_tmr - TW'(1);
        if (r_tmr == TW'(1)) begin
          r_state <= COLLECT;
          r_sr    <= '0;
          r_bcnt  <= '0;
          r_fail  <= '0;
        end
      end else if (pwd_we) begin
        r_pwd  <= pwd_din;
        r_sr   <= '0;
        r_fill <= '0;
        r_bcnt <= '0;
        r_fail <= '0;
      end else if (in_valid) begin
        r_sr <= w_cand[PWD_W-2:0];
        if (MODE == 0) begin
          if (r_fill != CW'(PWD_W)) r_fill <= r_fill + CW'(1);
          r_out <= w_full && w_match;
        end else begin
          r_bcnt <= w_last ? '0 : r_bcnt + CW'(1);
          if (w_last) begin
            if (w_match) begin
              r_out  <= 1'b1;
              r_fail <= '0;
            end else if (w_fail_inc == (FW+1)'(MAX_FAIL)) begin
              r_state <= LOCKED;
              r_fail  <= FW'(MAX_FAIL);
              r_tmr   <= TW'(LOCK_CYCLES);
            end else begin
              r_fail <= w_fail_inc[FW-1:0];
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pwd_lock.sv
// tb_pwd_lock: directed checks of both detection modes, password write, lockout and async reset
module tb_pwd_lock;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       pwd_we = 1'b0;
  logic [3:0] pwd_din = 4'b0000;
  logic       out0, locked0, out1, locked1;
  logic [1:0] fail0, fail1;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pwd_lock #(.MODE(0)) u0 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pwd_we(pwd_we),
    .pwd_din(pwd_din), .out(out0), .locked(locked0), .fail_cnt(fail0)
  );
  pwd_lock #(.MODE(1)) u1 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pwd_we(pwd_we),
    .pwd_din(pwd_din), .out(out1), .locked(locked1), .fail_cnt(fail1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    @(negedge clk);
    in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_pwd(input logic [3:0] p, input logic with_bit);
    @(negedge clk);
    pwd_din = p;
    pwd_we = 1'b1;
    in = 1'b1;
    in_valid = with_bit;
    @(posedge clk);
    #1;
    pwd_we = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic fail_attempt();
    for (int i = 0; i < 4; i++) send(1'b0);
  endtask

  logic [7:0] seq36 = 8'b0100_1001;
  logic [7:0] exp36 = 8'b0000_1001;
  logic [3:0] pin = 4'b1001;

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out0", out0, 0);
    chk("rst_locked0", locked0, 0);
    chk("rst_out1", out1, 0);
    chk("rst_locked1", locked1, 0);
    chk("rst_fail1", fail1, 0);

    for (int i = 0; i < 8; i++) begin
      send(seq36[7-i]);
      chk($sformatf("m0_overlap_b%0d", i+1), out0, exp36[7-i]);
    end
    chk("m0_fail_held", fail0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(pin[3-i]);
      chk($sformatf("m0_gap_b%0d", i+1), out0, i == 3);
      step();
      chk($sformatf("m0_gap_idle%0d", i+1), out0, 0);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(pin[3-i]);
      chk($sformatf("m1_match_b%0d", i+1), out1, i == 3);
      chk($sformatf("m1_match_fail%0d", i+1), fail1, 0);
    end
    fail_attempt();
    chk("m1_one_fail", fail1, 1);
    for (int i = 0; i < 4; i++) send(pin[3-i]);
    chk("m1_match_clears_out", out1, 1);
    chk("m1_match_clears_fail", fail1, 0);

    do_reset();
    fail_attempt();
    chk("m1_fail1", fail1, 1);
    chk("m1_fail1_unlocked", locked1, 0);
    fail_attempt();
    chk("m1_fail2", fail1, 2);
    fail_attempt();
    chk("m1_lock_on", locked1, 1);
    chk("m1_lock_fail3", fail1, 3);
    chk("m1_lock_out", out1, 0);
    chk("m0_never_locks", locked0, 0);
    in = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("m1_lock_hold%0d", i), locked1, 1);
      chk($sformatf("m1_lock_noout%0d", i), out1, 0);
    end
    step();
    in_valid = 1'b0;
    chk("m1_lock_off", locked1, 0);
    chk("m1_lock_fail_clr", fail1, 0);
    for (int i = 0; i < 4; i++) send(pin[3-i]);
    chk("m1_after_lock_match", out1, 1);

    do_reset();
    write_pwd(4'b0110, 1'b1);
    chk("we_no_out", out1, 0);
    send(1'b0); send(1'b1); send(1'b1);
    chk("we_pre_out", out1, 0);
    send(1'b0);
    chk("we_new_pwd_match", out1, 1);
    for (int i = 0; i < 4; i++) send(pin[3-i]);
    chk("we_old_pwd_nomatch", out1, 0);
    chk("we_old_pwd_fail", fail1, 1);

    do_reset();
    write_pwd(4'b0110, 1'b0);
    fail_attempt();
    fail_attempt();
    fail_attempt();
    chk("rst_lock_on", locked1, 1);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_unlock", locked1, 0);
    chk("async_rst_fail", fail1, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(pin[3-i]);
      chk($sformatf("rst_init_pwd_b%0d", i+1), out1, i == 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
